// File: rtl/mult_seq_hs_pkg.sv
// mult_pkg: shared types and helpers for the sequential shift-add multiplier.
//   state_e      - controller states (IDLE, CALC, DONE)
//   res_width()  - product width for a given operand width
//   cnt_width()  - width of the step counter, able to hold N = pw/bpc
//   cond_negate()- two's-complement negate on a wide vector when neg is set;
//                  callers size-cast their operands in and the result out.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Working width of cond_negate. Wide enough for any product up to
  // 2*127 bits, which comfortably covers every practical PAYLOAD_BITS.
  localparam int unsigned NEG_W = 256;

  function automatic int unsigned res_width(input int unsigned pw);
    return 2 * pw;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned pw, input int unsigned bpc);
    return $clog2(pw / bpc + 1);
  endfunction

  function automatic logic [NEG_W-1:0] cond_negate(input logic [NEG_W-1:0] v, input logic neg);
    return neg ? ((~v) + NEG_W'(1)) : v;
  endfunction

endpackage

// File: rtl/mult_seq_hs_if.sv
// mult_seq_hs_if: operand/result handshake bundle of mult_seq_hs.
//   IN_VALID_I/IN_READY_O   operand channel; SIGNED_I, OPER_ONE_I, OPER_TWO_I ride on it
//   OUT_VALID_O/OUT_READY_I result channel; DATA_O rides on it
//   BUSY_O                  high while an operation is in flight (CALC or DONE)
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. The producer keeps valid/payload stable until that edge; the
// result side holds OUT_VALID_O and DATA_O steady until it is taken. Input
// valid without ready is simply dropped, never queued.
interface mult_seq_hs_if #(
  parameter int unsigned PAYLOAD_BITS = 8
);
  logic                      IN_VALID_I;
  logic                      IN_READY_O;
  logic                      SIGNED_I;
  logic [PAYLOAD_BITS-1:0]   OPER_ONE_I;
  logic [PAYLOAD_BITS-1:0]   OPER_TWO_I;
  logic                      OUT_VALID_O;
  logic                      OUT_READY_I;
  logic [2*PAYLOAD_BITS-1:0] DATA_O;
  logic                      BUSY_O;

  // slave: the multiplier itself
  modport slave (
    input  IN_VALID_I, SIGNED_I, OPER_ONE_I, OPER_TWO_I, OUT_READY_I,
    output IN_READY_O, OUT_VALID_O, DATA_O, BUSY_O
  );

  // master: operand producer / result consumer
  modport master (
    output IN_VALID_I, SIGNED_I, OPER_ONE_I, OPER_TWO_I, OUT_READY_I,
    input  IN_READY_O, OUT_VALID_O, DATA_O, BUSY_O
  );
endinterface

// File: rtl/mult_seq_hs_step.sv
// mult_step: one combinational shift-add step.
//   acc_i   [2*PAYLOAD_BITS]  accumulator before the step
//   mcand_i [PAYLOAD_BITS]    multiplicand magnitude
//   slice_i [BITS_PER_CYCLE]  low multiplier bits retired this step
//   acc_o   [2*PAYLOAD_BITS]  accumulator after the step
// The accumulator is kept right-shifting: each partial product is added at
// bit PAYLOAD_BITS and the sum shifted right by BITS_PER_CYCLE. After N steps
// the product lands exactly in place, so no per-step position is needed. The
// bits shifted out are always zero.
module mult_step
  import mult_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS   = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic [res_width(PAYLOAD_BITS)-1:0] acc_i,
  input  logic [PAYLOAD_BITS-1:0]            mcand_i,
  input  logic [BITS_PER_CYCLE-1:0]          slice_i,
  output logic [res_width(PAYLOAD_BITS)-1:0] acc_o
);
  localparam int unsigned RES_W = res_width(PAYLOAD_BITS);
  localparam int unsigned PP_W  = PAYLOAD_BITS + BITS_PER_CYCLE;
  localparam int unsigned SUM_W = RES_W + BITS_PER_CYCLE;

  logic [PP_W-1:0]  pp;
  logic [SUM_W-1:0] sum;

  always_comb begin
    pp    = PP_W'(mcand_i) * PP_W'(slice_i);
    // The extra BITS_PER_CYCLE of headroom absorbs the carry before the shift.
    sum   = SUM_W'(acc_i) + (SUM_W'(pp) << PAYLOAD_BITS);
    acc_o = RES_W'(sum >> BITS_PER_CYCLE);
  end
endmodule

// File: rtl/mult_seq_hs.sv
// mult_seq_hs: sequential shift-add multiplier with valid/ready handshakes.
//   CLK_I    clock, rising edge
//   RST_N_I  synchronous active-low reset
//   bus      mult_seq_hs_if.slave (operands, mode, product, busy)
//   STATE_O  current controller state, for observation
// Signed operations are done on magnitudes; the sign (MSB(a) ^ MSB(b)) is
// applied when the product is registered. The magnitude of the most negative
// operand is exactly PAYLOAD_BITS wide as an unsigned value, so it needs no
// special case. PAYLOAD_BITS >= 2; BITS_PER_CYCLE in {1,2,4} dividing it.
// A result appears N = PAYLOAD_BITS/BITS_PER_CYCLE cycles after acceptance.
module mult_seq_hs
  import mult_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS   = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic  CLK_I,
  input  logic  RST_N_I,
  mult_seq_hs_if.slave bus,
  output state_e STATE_O
);
  localparam int unsigned RES_W = res_width(PAYLOAD_BITS);
  localparam int unsigned CNT_W = cnt_width(PAYLOAD_BITS, BITS_PER_CYCLE);
  localparam int unsigned N     = PAYLOAD_BITS / BITS_PER_CYCLE;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [RES_W-1:0]        acc_q;
  logic [PAYLOAD_BITS-1:0] mcand_q;
  logic [PAYLOAD_BITS-1:0] mplier_q;
  logic                    sign_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    busy_q;
  logic [RES_W-1:0]        data_q;

  logic [PAYLOAD_BITS-1:0] mag_a;
  logic [PAYLOAD_BITS-1:0] mag_b;
  logic [RES_W-1:0]        acc_d;
  logic [RES_W-1:0]        result_d;

  mult_step #(
    .PAYLOAD_BITS  (PAYLOAD_BITS),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .acc_i  (acc_q),
    .mcand_i(mcand_q),
    .slice_i(mplier_q[BITS_PER_CYCLE-1:0]),
    .acc_o  (acc_d)
  );

  always_comb begin
    mag_a    = PAYLOAD_BITS'(cond_negate(NEG_W'(bus.OPER_ONE_I),
                                         bus.SIGNED_I & bus.OPER_ONE_I[PAYLOAD_BITS-1]));
    mag_b    = PAYLOAD_BITS'(cond_negate(NEG_W'(bus.OPER_TWO_I),
                                         bus.SIGNED_I & bus.OPER_TWO_I[PAYLOAD_BITS-1]));
    // Final product taken straight from the last step's sum.
    result_d = RES_W'(cond_negate(NEG_W'(acc_d), sign_q));
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      sign_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          // Gate on the registered ready so the first edge out of reset,
          // where ready was still low, does not accept.
          if (bus.IN_VALID_I && in_ready_q) begin
            mcand_q    <= mag_a;
            mplier_q   <= mag_b;
            sign_q     <= bus.SIGNED_I &
                          (bus.OPER_ONE_I[PAYLOAD_BITS-1] ^ bus.OPER_TWO_I[PAYLOAD_BITS-1]);
            acc_q      <= '0;
            cnt_q      <= CNT_W'(N);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= CALC;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> BITS_PER_CYCLE;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            data_q      <= result_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.OUT_READY_I) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.IN_READY_O  = in_ready_q;
  assign bus.OUT_VALID_O = out_valid_q;
  assign bus.DATA_O      = data_q;
  assign bus.BUSY_O      = busy_q;
  assign STATE_O         = state_q;
endmodule

// File: tb/tb_mult_seq_hs.sv
// tb_mult_seq_hs: directed and randomised checks of mult_seq_hs.
// Three instances: 8-bit/1 bit per cycle, 16-bit/2, 16-bit/4.
module tb_mult_seq_hs;
  import mult_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  mult_seq_hs_if #(.PAYLOAD_BITS(8))  if8();
  mult_seq_hs_if #(.PAYLOAD_BITS(16)) if16a();
  mult_seq_hs_if #(.PAYLOAD_BITS(16)) if16b();
  state_e st8, st16a, st16b;

  mult_seq_hs #(.PAYLOAD_BITS(8), .BITS_PER_CYCLE(1)) dut8 (
    .CLK_I(clk), .RST_N_I(rst_n), .bus(if8), .STATE_O(st8));
  mult_seq_hs #(.PAYLOAD_BITS(16), .BITS_PER_CYCLE(2)) dut16a (
    .CLK_I(clk), .RST_N_I(rst_n), .bus(if16a), .STATE_O(st16a));
  mult_seq_hs #(.PAYLOAD_BITS(16), .BITS_PER_CYCLE(4)) dut16b (
    .CLK_I(clk), .RST_N_I(rst_n), .bus(if16b), .STATE_O(st16b));

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    logic [15:0] ua;
    logic [15:0] ub;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    ua = {8'h00, a};
    ub = {8'h00, b};
    if (s) return sa * sb;
    return ua * ub;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_ready8(input string tag);
    int guard = 0;
    while (!if8.IN_READY_O && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_in_ready"}, 64'(if8.IN_READY_O), 64'd1);
  endtask

  // One operation on the 8-bit instance with OUT_READY_I held high.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic s, input logic [15:0] exp);
    int lat;
    wait_ready8(tag);
    if8.OPER_ONE_I = a;
    if8.OPER_TWO_I = b;
    if8.SIGNED_I   = s;
    if8.IN_VALID_I = 1'b1;
    @(negedge clk);
    if8.IN_VALID_I = 1'b0;
    lat = 0;
    while (!if8.OUT_VALID_O && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd8);
    check({tag, "_data"}, 64'(if8.DATA_O), 64'(exp));
    @(negedge clk);
    check({tag, "_valid_one_cycle"}, 64'(if8.OUT_VALID_O), 64'd0);
  endtask

  function automatic logic rdy16(input int sel);
    return (sel == 0) ? if16a.IN_READY_O : if16b.IN_READY_O;
  endfunction
  function automatic logic vld16(input int sel);
    return (sel == 0) ? if16a.OUT_VALID_O : if16b.OUT_VALID_O;
  endfunction
  function automatic logic [31:0] dat16(input int sel);
    return (sel == 0) ? if16a.DATA_O : if16b.DATA_O;
  endfunction

  task automatic run16(input string tag, input int sel, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [31:0] exp, input int exp_lat);
    int lat;
    int guard = 0;
    while (!rdy16(sel) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_in_ready"}, 64'(rdy16(sel)), 64'd1);
    if (sel == 0) begin
      if16a.OPER_ONE_I = a; if16a.OPER_TWO_I = b; if16a.SIGNED_I = s; if16a.IN_VALID_I = 1'b1;
    end else begin
      if16b.OPER_ONE_I = a; if16b.OPER_TWO_I = b; if16b.SIGNED_I = s; if16b.IN_VALID_I = 1'b1;
    end
    @(negedge clk);
    if16a.IN_VALID_I = 1'b0;
    if16b.IN_VALID_I = 1'b0;
    lat = 0;
    while (!vld16(sel) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_data"}, 64'(dat16(sel)), 64'(exp));
    @(negedge clk);
    check({tag, "_valid_one_cycle"}, 64'(vld16(sel)), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] held;
    logic        saw_valid;
    logic        stable_ok;
    int          lat;

    rst_n = 1'b0;
    if8.IN_VALID_I = 1'b0;   if8.SIGNED_I = 1'b0;   if8.OUT_READY_I = 1'b1;
    if8.OPER_ONE_I = '0;     if8.OPER_TWO_I = '0;
    if16a.IN_VALID_I = 1'b0; if16a.SIGNED_I = 1'b0; if16a.OUT_READY_I = 1'b1;
    if16a.OPER_ONE_I = '0;   if16a.OPER_TWO_I = '0;
    if16b.IN_VALID_I = 1'b0; if16b.SIGNED_I = 1'b0; if16b.OUT_READY_I = 1'b1;
    if16b.OPER_ONE_I = '0;   if16b.OPER_TWO_I = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready",  64'(if8.IN_READY_O),  64'd0);
    check("rst_out_valid", 64'(if8.OUT_VALID_O), 64'd0);
    check("rst_busy",      64'(if8.BUSY_O),      64'd0);
    check("rst_data",      64'(if8.DATA_O),      64'd0);
    check("rst_state",     64'(st8),             64'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_in_ready", 64'(if8.IN_READY_O), 64'd1);

    // Unsigned and signed directed products
    run8("u_93_ea",  8'h93, 8'hEA, 1'b0, 16'h865E);
    run8("s_93_ea",  8'h93, 8'hEA, 1'b1, 16'h095E);
    run8("s_80_7f",  8'h80, 8'h7F, 1'b1, 16'hC080);
    run8("s_80_80",  8'h80, 8'h80, 1'b1, 16'h4000);
    run8("s_7f_80",  8'h7F, 8'h80, 1'b1, 16'hC080);
    run8("s_fb_00",  8'hFB, 8'h00, 1'b1, 16'h0000);
    run8("u_ff_01",  8'hFF, 8'h01, 1'b0, 16'h00FF);
    run8("s_ff_ff",  8'hFF, 8'hFF, 1'b1, 16'h0001);

    // Backpressure, plus operand changes and valid pulses while busy
    if8.OUT_READY_I = 1'b0;
    wait_ready8("bp");
    if8.OPER_ONE_I = 8'h93; if8.OPER_TWO_I = 8'hEA; if8.SIGNED_I = 1'b1; if8.IN_VALID_I = 1'b1;
    @(negedge clk);
    if8.IN_VALID_I = 1'b0;
    check("bp_busy_calc",     64'(if8.BUSY_O),     64'd1);
    check("bp_in_ready_calc", 64'(if8.IN_READY_O), 64'd0);
    lat = 0;
    while (!if8.OUT_VALID_O && lat < 100) begin
      if (lat == 2) begin
        if8.OPER_ONE_I = 8'h11; if8.OPER_TWO_I = 8'h22; if8.SIGNED_I = 1'b0; if8.IN_VALID_I = 1'b1;
      end else begin
        if8.IN_VALID_I = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    if8.IN_VALID_I = 1'b0;
    check("bp_latency", 64'(lat), 64'd8);
    check("bp_data",    64'(if8.DATA_O), 64'h095E);
    held = if8.DATA_O;
    stable_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        if8.OPER_ONE_I = 8'h05; if8.OPER_TWO_I = 8'h07; if8.IN_VALID_I = 1'b1;
      end else begin
        if8.IN_VALID_I = 1'b0;
      end
      @(negedge clk);
      if (!(if8.OUT_VALID_O === 1'b1 && if8.DATA_O === held &&
            if8.IN_READY_O === 1'b0 && if8.BUSY_O === 1'b1))
        stable_ok = 1'b0;
    end
    if8.IN_VALID_I = 1'b0;
    check("bp_hold_stable", 64'(stable_ok), 64'd1);
    check("bp_hold_data",   64'(if8.DATA_O), 64'h095E);
    if8.OUT_READY_I = 1'b1;
    @(negedge clk);
    check("bp_release_valid",    64'(if8.OUT_VALID_O), 64'd0);
    check("bp_release_in_ready", 64'(if8.IN_READY_O),  64'd1);
    check("bp_release_busy",     64'(if8.BUSY_O),      64'd0);
    check("bp_release_state",    64'(st8),             64'(IDLE));
    check("bp_release_data",     64'(if8.DATA_O),      64'h095E);
    @(negedge clk);
    check("bp_no_queued_op", 64'(st8), 64'(IDLE));

    // Reset in the 3rd CALC cycle
    wait_ready8("rst_mid");
    if8.OPER_ONE_I = 8'h12; if8.OPER_TWO_I = 8'h34; if8.SIGNED_I = 1'b0; if8.IN_VALID_I = 1'b1;
    @(negedge clk);             // accepting edge passed
    if8.IN_VALID_I = 1'b0;
    @(negedge clk);             // CALC 1 done
    @(negedge clk);             // CALC 2 done; now inside CALC cycle 3
    check("rst_mid_state_calc", 64'(st8), 64'(CALC));
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_in_ready",  64'(if8.IN_READY_O),  64'd0);
    check("rst_mid_out_valid", 64'(if8.OUT_VALID_O), 64'd0);
    check("rst_mid_busy",      64'(if8.BUSY_O),      64'd0);
    check("rst_mid_data",      64'(if8.DATA_O),      64'd0);
    check("rst_mid_state",     64'(st8),             64'(IDLE));
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if8.OUT_VALID_O) saw_valid = 1'b1;
    end
    check("rst_mid_no_result", 64'(saw_valid), 64'd0);
    run8("u_ff_ff_after_rst", 8'hFF, 8'hFF, 1'b0, 16'hFE01);

    // 16-bit operands, 2 and 4 bits per cycle
    run16("b2_u_ffff", 0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 8);
    run16("b4_u_ffff", 1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 4);
    run16("b2_s_8000", 0, 16'h8000, 16'hFFFF, 1'b1, 32'h00008000, 8);
    run16("b4_s_8000", 1, 16'h8000, 16'hFFFF, 1'b1, 32'h00008000, 4);
    run16("b4_s_1234", 1, 16'h1234, 16'hFFFE, 1'b1, 32'hFFFFDB98, 4);

    // Random operations with random gaps and backpressure
    for (int n = 0; n < 1000; n++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rs;
      logic       done;
      int         gap;
      int         guard;
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        if8.OUT_READY_I = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      guard = 0;
      while (!if8.IN_READY_O && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if8.OPER_ONE_I = ra; if8.OPER_TWO_I = rb; if8.SIGNED_I = rs; if8.IN_VALID_I = 1'b1;
      exp_q.push_back(model8(ra, rb, rs));
      @(negedge clk);
      if8.IN_VALID_I = 1'b0;
      if8.OPER_ONE_I = 8'($urandom);
      if8.OPER_TWO_I = 8'($urandom);
      if8.SIGNED_I   = 1'($urandom_range(0, 1));
      done  = 1'b0;
      guard = 0;
      while (!done && guard < 200) begin
        if8.OUT_READY_I = 1'($urandom_range(0, 1));
        if (if8.OUT_VALID_O && if8.OUT_READY_I) begin
          check("rand_data", 64'(if8.DATA_O), 64'(exp_q.pop_front()));
          done = 1'b1;
        end
        @(negedge clk);
        guard++;
      end
      check("rand_result_seen", 64'(done), 64'd1);
    end
    check("rand_queue_empty", 64'(exp_q.size()), 64'd0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_seq_hs.md
Name: mult_seq_hs

Overview:
Parametrised sequential shift-add multiplier, successor to the fixed 8-bit LOAD-driven multiplier. Adds valid/ready handshakes on input and output with output backpressure, per-operation signed/unsigned mode, and a configurable number of multiplier bits retired per cycle. It sits between operand producers and result consumers in the datapath and replaces the level-sensitive LOAD interface.

Parameters:
PAYLOAD_BITS, 8, operand width; result width is 2*PAYLOAD_BITS; must be at least 2.
BITS_PER_CYCLE, 1, multiplier bits consumed per CALC cycle; must be 1, 2 or 4 and must divide PAYLOAD_BITS.

Ports:
CLK_I  in  1  clock; all logic on rising edge.
RST_N_I  in  1  synchronous active-low reset.
IN_VALID_I  in  1  operands and mode are valid.
IN_READY_O  out  1  block accepts a new operation.
SIGNED_I  in  1  1 = two's-complement operands; 0 = unsigned; captured with the operands.
OPER_ONE_I  in  PAYLOAD_BITS  multiplicand.
OPER_TWO_I  in  PAYLOAD_BITS  multiplier.
OUT_VALID_O  out  1  DATA_O holds a finished product.
OUT_READY_I  in  1  consumer accepts the result.
DATA_O  out  2*PAYLOAD_BITS  product.
BUSY_O  out  1  high in CALC and DONE.

Behaviour:
- Reset (RST_N_I=0 at an edge): state IDLE; IN_READY_O=0 during the reset cycle and 1 from the first edge with RST_N_I=1; OUT_VALID_O=0, BUSY_O=0, DATA_O=0; counter and accumulator cleared. A reset mid-operation abandons the operation and emits no result.
- N = PAYLOAD_BITS/BITS_PER_CYCLE.
- IDLE: IN_READY_O=1. On an edge with IN_VALID_I=1, capture the operands and SIGNED_I, then go to CALC. In signed mode, store the operand magnitudes and sign = MSB(a) XOR MSB(b).
- CALC: IN_READY_O=0. Each cycle, add (multiplicand * low BITS_PER_CYCLE bits of multiplier), shifted to its position, into the 2*PAYLOAD_BITS accumulator. Shift the multiplier right by BITS_PER_CYCLE. Decrement the counter.
- After the N-th CALC cycle, register DATA_O: the accumulator, two's-complement negated if the sign is set. Set OUT_VALID_O=1 and go to DONE.
- OUT_VALID_O rises exactly N cycles after the accepting edge; with defaults, 8 cycles.
- DONE: DATA_O and OUT_VALID_O are held stable while OUT_READY_I=0, for unlimited backpressure. On an edge with OUT_READY_I=1, go to IDLE and clear OUT_VALID_O. DATA_O keeps its last value.
- An OUT_READY_I that is already high when DONE is entered causes acceptance on the first DONE edge.
- No accept in DONE, so back-to-back throughput is one operation per N+2 cycles.
- IN_VALID_I while not ready is ignored; it is not queued.
- Operand changes during CALC/DONE have no effect.
- Width rules: the magnitude of the most negative operand (e.g. 0x80) is PAYLOAD_BITS unsigned and is handled exactly. Every signed/unsigned product fits in 2*PAYLOAD_BITS with no overflow.
- OUT_READY_I is ignored outside DONE.

Decomposition:
- Package mult_pkg:
  - state enum {IDLE, CALC, DONE};
  - localparam width helpers (result width, counter width = $clog2(N+1));
  - function for conditional two's-complement negate.
- One sub-module: mult_step. It is combinational: accumulator, multiplicand and multiplier slice in; next accumulator out. It is parametrised by PAYLOAD_BITS and BITS_PER_CYCLE.

Test Plan:
- Unsigned, defaults: a=0x93, b=0xEA, SIGNED_I=0, OUT_READY_I=1 -> DATA_O=0x865E, OUT_VALID_O high exactly 8 cycles after the accepting edge, for one cycle.
- Signed: a=0x93 (-109), b=0xEA (-22) -> 0x095E. Then a=0x80 (-128), b=0x7F (127) -> 0xC080. Then a=0x80, b=0x80 -> 0x4000.
- Backpressure: hold OUT_READY_I=0 for 20 cycles after OUT_VALID_O rises -> DATA_O and OUT_VALID_O stable, IN_READY_O=0. Also change the operands and pulse IN_VALID_I while busy -> no effect. Release -> return to IDLE the next cycle.
- Reset mid-CALC: assert RST_N_I=0 on the 3rd CALC cycle -> all outputs 0 at the next edge, no OUT_VALID_O. The next op, 0xFF*0xFF unsigned, -> 0xFE01.
- BITS_PER_CYCLE=2 and =4, PAYLOAD_BITS=16: a=0xFFFF, b=0xFFFF unsigned -> 0xFFFE0001 with latency 8 and 4 respectively. Signed 0x8000*0xFFFF -> 0x00008000.
- Random: 1000 random ops with random modes and random IN_VALID_I/OUT_READY_I gaps -> every result matches a reference model, in order, with no drops.
